// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RISC-V integer pipeline.
// Holds the EX result bundle in the MS register, performs the data-memory
// handshake (IDLE/REQ/WAIT), aligns/extends load data and registers the
// result into the WB stage register.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned H/HU/W accesses are
// trapped (ms_misalign/ms_badaddr) instead of being truncated to size.
module mem_stage #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic [4:0]          ex_wb_addr,
    input  logic                ex_rf_wen,
    input  logic                ex_mem_val,
    input  logic                ex_mem_fcn,
    input  logic [2:0]          ex_mem_typ,
    input  logic [XLEN-1:0]     ex_alu_out,
    input  logic [XLEN-1:0]     ex_rs2_data,
    output logic                mem_stall,
    output logic [4:0]          ms_wb_addr,
    output logic                ms_rf_wen,
    output logic [XLEN-1:0]     ms_wb_data,
    output logic [4:0]          wb_wb_addr,
    output logic                wb_rf_wen,
    output logic [XLEN-1:0]     wb_wb_data,
    output logic                dmem_req_valid,
    input  logic                dmem_req_ready,
    output logic [ADDR_W-1:0]   dmem_req_addr,
    output logic                dmem_req_fcn,
    output logic [XLEN-1:0]     dmem_req_wdata,
    output logic [XLEN/8-1:0]   dmem_req_wmask,
    input  logic                dmem_resp_valid,
    input  logic [XLEN-1:0]     dmem_resp_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic                ms_misalign,
    output logic [ADDR_W-1:0]   ms_badaddr
`endif
);

    localparam logic [2:0] MT_B  = 3'd1;
    localparam logic [2:0] MT_H  = 3'd2;
    localparam logic [2:0] MT_BU = 3'd5;
    localparam logic [2:0] MT_HU = 3'd6;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t state_q, state_d;

    logic              ms_valid_q, ms_rf_wen_q, ms_mem_val_q, ms_mem_fcn_q;
    logic [4:0]        ms_wb_addr_q;
    logic [2:0]        ms_mem_typ_q;
    logic [XLEN-1:0]   ms_alu_q, ms_rs2_q;

    logic              is_byte, is_half;
    logic [1:0]        off;
    logic              misalign, mem_op, resp_done;
    logic [XLEN-1:0]   shifted, load_data;

    // MS register: capture EX bundle unless stalled; bubbles clear wen/mem_val
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ms_valid_q   <= 1'b0;
            ms_wb_addr_q <= '0;
            ms_rf_wen_q  <= 1'b0;
            ms_mem_val_q <= 1'b0;
            ms_mem_fcn_q <= 1'b0;
            ms_mem_typ_q <= '0;
            ms_alu_q     <= '0;
            ms_rs2_q     <= '0;
        end else if (!mem_stall) begin
            ms_valid_q   <= ex_valid;
            ms_wb_addr_q <= ex_wb_addr;
            ms_rf_wen_q  <= ex_valid & ex_rf_wen;
            ms_mem_val_q <= ex_valid & ex_mem_val;
            ms_mem_fcn_q <= ex_mem_fcn;
            ms_mem_typ_q <= ex_mem_typ;
            ms_alu_q     <= ex_alu_out;
            ms_rs2_q     <= ex_rs2_data;
        end
    end

    assign is_byte = (ms_mem_typ_q[1:0] == 2'b01);
    assign is_half = (ms_mem_typ_q[1:0] == 2'b10);

    // Byte offset within the word after truncating low bits to the access size
    always_comb begin
        off = 2'b00;
        if (is_byte)      off = ms_alu_q[1:0];
        else if (is_half) off = {ms_alu_q[1], 1'b0};
    end

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = ms_valid_q && ms_mem_val_q &&
                      ((is_half && ms_alu_q[0]) ||
                       (!is_byte && !is_half && (ms_alu_q[1:0] != 2'b00)));
    assign ms_misalign = misalign;
    assign ms_badaddr  = misalign ? ms_alu_q[ADDR_W-1:0] : '0;
`else
    assign misalign = 1'b0;
`endif

    assign mem_op = ms_valid_q && ms_mem_val_q && !misalign;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: one outstanding request; responses outside WAIT are dropped
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (mem_op) state_d = dmem_req_ready ? S_WAIT : S_REQ;
            S_REQ:  if (dmem_req_ready) state_d = S_WAIT;
            S_WAIT: if (dmem_resp_valid) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request valid, completion and stall
    always_comb begin
        resp_done      = (state_q == S_WAIT) && dmem_resp_valid;
        dmem_req_valid = mem_op && (state_q != S_WAIT);
        mem_stall      = mem_op && !resp_done;
    end

    assign dmem_req_addr = {ms_alu_q[ADDR_W-1:2], 2'b00};
    assign dmem_req_fcn  = ms_mem_fcn_q;

    // Store lane replication and byte strobes (loads drive no strobes)
    always_comb begin
        dmem_req_wdata = ms_rs2_q;
        dmem_req_wmask = '0;
        if (is_byte)      dmem_req_wdata = {(XLEN/8){ms_rs2_q[7:0]}};
        else if (is_half) dmem_req_wdata = {(XLEN/16){ms_rs2_q[15:0]}};
        if (ms_mem_fcn_q) begin
            if (is_byte)      dmem_req_wmask = 4'b0001 << off;
            else if (is_half) dmem_req_wmask = 4'b0011 << off;
            else              dmem_req_wmask = '1;
        end
    end

    // Load alignment and sign/zero extension
    always_comb begin
        shifted   = dmem_resp_data >> {off, 3'b000};
        load_data = shifted;
        case (ms_mem_typ_q)
            MT_B:  load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            MT_BU: load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
            MT_H:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            MT_HU: load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
            default: load_data = shifted;
        endcase
    end

    assign ms_wb_addr = ms_wb_addr_q;
    assign ms_rf_wen  = ms_rf_wen_q && !misalign;
    assign ms_wb_data = (mem_op && !ms_mem_fcn_q && resp_done) ? load_data : ms_alu_q;

    // WB register: bubble while stalled, otherwise take the MS result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_wb_addr <= '0;
            wb_rf_wen  <= 1'b0;
            wb_wb_data <= '0;
        end else if (mem_stall) begin
            wb_wb_addr <= '0;
            wb_rf_wen  <= 1'b0;
            wb_wb_data <= '0;
        end else begin
            wb_wb_addr <= ms_wb_addr;
            wb_rf_wen  <= ms_rf_wen && ms_valid_q;
            wb_wb_data <= ms_wb_data;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage with a byte-level memory
// reference model, a randomized data-memory responder and directed cases.
module tb_mem_stage;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 1'b0;
    logic [4:0]        ex_wb_addr = '0;
    logic              ex_rf_wen = 1'b0;
    logic              ex_mem_val = 1'b0;
    logic              ex_mem_fcn = 1'b0;
    logic [2:0]        ex_mem_typ = '0;
    logic [XLEN-1:0]   ex_alu_out = '0;
    logic [XLEN-1:0]   ex_rs2_data = '0;
    logic              mem_stall;
    logic [4:0]        ms_wb_addr;
    logic              ms_rf_wen;
    logic [XLEN-1:0]   ms_wb_data;
    logic [4:0]        wb_wb_addr;
    logic              wb_rf_wen;
    logic [XLEN-1:0]   wb_wb_data;
    logic              dmem_req_valid;
    logic              dmem_req_ready;
    logic [ADDR_W-1:0] dmem_req_addr;
    logic              dmem_req_fcn;
    logic [XLEN-1:0]   dmem_req_wdata;
    logic [XLEN/8-1:0] dmem_req_wmask;
    logic              dmem_resp_valid;
    logic [XLEN-1:0]   dmem_resp_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic              ms_misalign;
    logic [ADDR_W-1:0] ms_badaddr;
`endif

    always #5 clk = ~clk;

    mem_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_wb_addr(ex_wb_addr), .ex_rf_wen(ex_rf_wen),
        .ex_mem_val(ex_mem_val), .ex_mem_fcn(ex_mem_fcn), .ex_mem_typ(ex_mem_typ),
        .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data),
        .mem_stall(mem_stall), .ms_wb_addr(ms_wb_addr), .ms_rf_wen(ms_rf_wen),
        .ms_wb_data(ms_wb_data), .wb_wb_addr(wb_wb_addr), .wb_rf_wen(wb_rf_wen),
        .wb_wb_data(wb_wb_data), .dmem_req_valid(dmem_req_valid),
        .dmem_req_ready(dmem_req_ready), .dmem_req_addr(dmem_req_addr),
        .dmem_req_fcn(dmem_req_fcn), .dmem_req_wdata(dmem_req_wdata),
        .dmem_req_wmask(dmem_req_wmask), .dmem_resp_valid(dmem_resp_valid),
        .dmem_resp_data(dmem_resp_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .ms_misalign(ms_misalign), .ms_badaddr(ms_badaddr)
`endif
    );

    typedef struct { logic [4:0] addr; logic [31:0] data; } wb_t;
    typedef struct { logic [31:0] addr; logic fcn; logic [3:0] wmask; logic [31:0] wdata; } req_t;

    wb_t         exp_wb[$];
    req_t        exp_req[$];
    logic [7:0]  ref_mem [1024];
    logic [31:0] smem [256];

    int checks = 0;
    int errors = 0;

    logic slave_rnd = 1'b0;
    int   cfg_ready_lo = 0;
    int   cfg_resp_dly = 0;

    logic        first_req_valid, first_req_fcn;
    logic [31:0] first_req_addr, first_req_wdata;
    logic [3:0]  first_req_wmask;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic int unsigned acc_size(input logic [2:0] typ);
        if (typ == 3'd1 || typ == 3'd5) return 1;
        if (typ == 3'd2 || typ == 3'd6) return 2;
        return 4;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] typ, input int unsigned addr);
`ifdef MEM_MISALIGN_TRAP_EN
        return (addr % acc_size(typ)) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] typ, input int unsigned addr);
        int unsigned sz = acc_size(typ);
        int unsigned ea = addr - (addr % sz);
        logic [63:0] v = '0;
        for (int unsigned k = 0; k < sz; k++) v |= 64'(ref_mem[ea + k]) << (8 * k);
        if ((typ == 3'd1 || typ == 3'd2) && v[8 * sz - 1]) v |= ~((64'd1 << (8 * sz)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic poke_word(input int unsigned addr, input logic [31:0] val);
        smem[addr / 4] = val;
        for (int unsigned k = 0; k < 4; k++) ref_mem[(addr & ~32'd3) + k] = val[8 * k +: 8];
    endtask

    // Reference model: what the accepted instruction must produce
    task automatic model(input logic rfw, input logic mv, input logic fcn,
                         input logic [2:0] typ, input logic [31:0] alu, input logic [31:0] rs2);
        int unsigned sz = acc_size(typ);
        int unsigned a = alu;
        int unsigned ea = a - (a % sz);
        logic mis = mv && is_misaligned(typ, a);
        req_t r;
        wb_t w;
        if (mv && !mis) begin
            r.addr  = ea & ~32'd3;
            r.fcn   = fcn;
            r.wmask = fcn ? 4'(((1 << sz) - 1) << (ea % 4)) : 4'b0000;
            r.wdata = '0;
            for (int unsigned l = 0; l < 4; l++) r.wdata[8 * l +: 8] = 8'(rs2 >> (8 * (l % sz)));
            exp_req.push_back(r);
            if (fcn) for (int unsigned k = 0; k < sz; k++) ref_mem[ea + k] = 8'(rs2 >> (8 * k));
        end
        if (rfw && !mis) begin
            w.addr = 5'(0);
            w.data = (mv && !fcn) ? ref_load(typ, a) : alu;
            exp_wb.push_back(w);
        end
    endtask

    // Present one EX instruction and hold it until MS accepts it
    task automatic issue(input logic v, input logic [4:0] wa, input logic rfw, input logic mv,
                         input logic fcn, input logic [2:0] typ, input logic [31:0] alu,
                         input logic [31:0] rs2);
        int n = 0;
        ex_valid = v; ex_wb_addr = wa; ex_rf_wen = rfw; ex_mem_val = mv;
        ex_mem_fcn = fcn; ex_mem_typ = typ; ex_alu_out = alu; ex_rs2_data = rs2;
        do begin
            @(negedge clk);
            n++;
        end while (mem_stall && n < 100);
        if (mem_stall) begin
            checks++; errors++;
            $display("FAIL issue_timeout: mem_stall actual 1 after %0d cycles required 0", n);
        end else if (v) begin
            model(rfw, mv, fcn, typ, alu, rs2);
            if (rfw && !(mv && is_misaligned(typ, alu))) exp_wb[exp_wb.size() - 1].addr = wa;
        end
        @(posedge clk); #1;
        ex_valid = 1'b0; ex_rf_wen = 1'b0; ex_mem_val = 1'b0;
    endtask

    // Count stall cycles of the op now in MS; ends on the completion cycle
    task automatic wait_done(output int n);
        n = 0;
        @(negedge clk);
        first_req_valid = dmem_req_valid; first_req_addr = dmem_req_addr;
        first_req_fcn = dmem_req_fcn; first_req_wdata = dmem_req_wdata;
        first_req_wmask = dmem_req_wmask;
        while (mem_stall && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Data-memory responder with request checking
    initial begin : slave
        int lo_cnt = 0, lo_tgt = 0, dly;
        int unsigned idx;
        logic [31:0] rdata, bp_addr;
        logic [36:0] bp_rest;
        logic bp_pend = 1'b0;
        req_t e;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = '0;
        forever begin
            @(posedge clk); #1;
            dmem_resp_valid = 1'b0;
            if (dmem_req_valid) begin
                if (lo_cnt < (slave_rnd ? lo_tgt : cfg_ready_lo)) begin
                    dmem_req_ready = 1'b0; lo_cnt++;
                end else dmem_req_ready = 1'b1;
            end else begin
                dmem_req_ready = 1'b0;
                if (slave_rnd && $urandom_range(0, 7) == 0) begin
                    dmem_resp_valid = 1'b1; dmem_resp_data = $urandom;
                end
            end
            @(negedge clk);
            if (bp_pend) begin
                check("req_hold_valid", 64'(dmem_req_valid), 64'd1);
                check("req_hold_addr", 64'(dmem_req_addr), 64'(bp_addr));
                check("req_hold_fields", 64'({dmem_req_fcn, dmem_req_wmask, dmem_req_wdata}), 64'(bp_rest));
            end
            bp_pend = dmem_req_valid && !dmem_req_ready;
            bp_addr = dmem_req_addr;
            bp_rest = {dmem_req_fcn, dmem_req_wmask, dmem_req_wdata};
            if (dmem_req_valid && dmem_req_ready) begin
                if (exp_req.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL req_unexpected: actual request addr 0x%0h required none", dmem_req_addr);
                end else begin
                    e = exp_req.pop_front();
                    check("req_addr", 64'(dmem_req_addr), 64'(e.addr));
                    check("req_fcn", 64'(dmem_req_fcn), 64'(e.fcn));
                    check("req_wmask", 64'(dmem_req_wmask), 64'(e.wmask));
                    if (e.fcn) check("req_wdata", 64'(dmem_req_wdata), 64'(e.wdata));
                end
                idx = 32'(dmem_req_addr[9:2]);
                if (dmem_req_fcn) begin
                    for (int l = 0; l < 4; l++)
                        if (dmem_req_wmask[l]) smem[idx][8 * l +: 8] = dmem_req_wdata[8 * l +: 8];
                    rdata = $urandom;
                end else rdata = smem[idx];
                lo_cnt = 0;
                lo_tgt = $urandom_range(0, 2);
                dly = slave_rnd ? $urandom_range(0, 2) : cfg_resp_dly;
                repeat (dly) begin
                    @(posedge clk); #1;
                    dmem_req_ready = 1'b0;
                end
                @(posedge clk); #1;
                dmem_req_ready = 1'b0; dmem_resp_valid = 1'b1; dmem_resp_data = rdata;
            end
        end
    end

    // WB monitor: pop the scoreboard whenever a register write retires
    initial begin : monitor
        logic prev_stall = 1'b0;
        wb_t e;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("wb_bubble_wen", 64'(wb_rf_wen), 64'd0);
                check("wb_bubble_addr", 64'(wb_wb_addr), 64'd0);
            end
            if (wb_rf_wen) begin
                if (exp_wb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected: actual write x%0d=0x%0h required none", wb_wb_addr, wb_wb_data);
                end else begin
                    e = exp_wb.pop_front();
                    check("wb_addr", 64'(wb_wb_addr), 64'(e.addr));
                    check("wb_data", 64'(wb_wb_data), 64'(e.data));
                end
            end
            prev_stall = mem_stall;
        end
    end

    initial begin : main
        int n, nreq;
        logic addr_ok, bad;
        logic [2:0] typs [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6};
        int unsigned kind;
        logic [2:0] t;
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            poke_word(32'(i * 4), w);
        end

        repeat (3) @(negedge clk);
        check("rst_ctrl", 64'({mem_stall, ms_rf_wen, wb_rf_wen, dmem_req_valid, dmem_req_fcn,
                               ms_wb_addr, wb_wb_addr, dmem_req_wmask}), 64'd0);
        check("rst_data", {ms_wb_data, wb_wb_data}, 64'd0);
        check("rst_req", {dmem_req_addr, dmem_req_wdata}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // ALU passthrough
        issue(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 3'd3, 32'h0000_1234, 32'h0);
        @(negedge clk);
        check("alu_ms_data", 64'(ms_wb_data), 64'h1234);
        check("alu_ms_addr_wen", 64'({ms_wb_addr, ms_rf_wen}), 64'({5'd5, 1'b1}));
        check("alu_no_stall", 64'(mem_stall), 64'd0);
        @(negedge clk);
        check("alu_wb", 64'({wb_rf_wen, wb_wb_data}), 64'({1'b1, 32'h1234}));

        // LB / LBU at 0x103
        poke_word(32'h100, 32'h80AA_BBCC);
        @(posedge clk); #1;
        issue(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 3'd1, 32'h103, 32'h0);
        wait_done(n);
        check("lb_stall_cycles", 64'(n), 64'd1);
        @(negedge clk);
        check("lb_wb_data", 64'(wb_wb_data), 64'hFFFF_FF80);
        @(posedge clk); #1;
        issue(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 3'd5, 32'h103, 32'h0);
        wait_done(n);
        check("lbu_stall_cycles", 64'(n), 64'd1);
        @(negedge clk);
        check("lbu_wb_data", 64'(wb_wb_data), 64'h0000_0080);

        // SH at 0x202
        @(posedge clk); #1;
        issue(1'b1, 5'd2, 1'b0, 1'b1, 1'b1, 3'd2, 32'h202, 32'h1234_ABCD);
        wait_done(n);
        check("sh_req", 64'({first_req_valid, first_req_fcn, first_req_wmask}), 64'({1'b1, 1'b1, 4'b1100}));
        check("sh_addr", 64'(first_req_addr), 64'h200);
        check("sh_wdata", 64'(first_req_wdata), 64'hABCD_ABCD);
        check("sh_stall_cycles", 64'(n), 64'd1);
        @(negedge clk);
        check("sh_wb_wen", 64'(wb_rf_wen), 64'd0);

        // LW at 0x40 with ready low for 3 cycles
        cfg_ready_lo = 3;
        @(posedge clk); #1;
        issue(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 3'd3, 32'h40, 32'h0);
        n = 0; nreq = 0; addr_ok = 1'b1;
        @(negedge clk);
        while (mem_stall && n < 100) begin
            n++;
            if (dmem_req_valid) begin
                nreq++;
                if (dmem_req_addr != 32'h40) addr_ok = 1'b0;
            end
            @(negedge clk);
        end
        check("bp_req_cycles", 64'(nreq), 64'd4);
        check("bp_stall_cycles", 64'(n), 64'd4);
        check("bp_addr_stable", 64'(addr_ok), 64'd1);
        cfg_ready_lo = 0;

        // Reset while waiting for the response; the late response must be ignored
        cfg_resp_dly = 6;
        @(posedge clk); #1;
        issue(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 3'd3, 32'h80, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_wb.delete();
        #1;
        check("midrst_ctrl", 64'({mem_stall, ms_rf_wen, wb_rf_wen, dmem_req_valid, dmem_req_fcn,
                                  ms_wb_addr, wb_wb_addr, dmem_req_wmask}), 64'd0);
        check("midrst_data", {ms_wb_data, wb_wb_data}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            bad |= mem_stall | dmem_req_valid | wb_rf_wen;
        end
        check("late_resp_ignored", 64'(bad), 64'd0);
        cfg_resp_dly = 0;

        // LW at 0x42
        @(posedge clk); #1;
        issue(1'b1, 5'd4, 1'b1, 1'b1, 1'b0, 3'd3, 32'h42, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
        @(negedge clk);
        check("mis_flag", 64'({ms_misalign, dmem_req_valid, mem_stall}), 64'({1'b1, 1'b0, 1'b0}));
        check("mis_badaddr", 64'(ms_badaddr), 64'h42);
        @(negedge clk);
        check("mis_wb_wen", 64'(wb_rf_wen), 64'd0);
`else
        wait_done(n);
        check("mis_req", 64'({first_req_valid, first_req_addr}), 64'({1'b1, 32'h40}));
        check("mis_stall_cycles", 64'(n), 64'd1);
`endif

        // Randomized mix against the reference model
        slave_rnd = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 400; i++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0)
                issue(1'b0, 5'($urandom), 1'b1, 1'b1, 1'($urandom), 3'd3, $urandom_range(0, 1023), $urandom);
            else if (kind <= 3)
                issue(1'b1, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 3'd3, $urandom, $urandom);
            else if (kind <= 6) begin
                t = typs[$urandom_range(0, 4)];
                issue(1'b1, 5'($urandom), 1'($urandom), 1'b1, 1'b0, t, $urandom_range(0, 1023), $urandom);
            end else begin
                t = typs[$urandom_range(0, 2)];
                issue(1'b1, 5'($urandom), 1'b0, 1'b1, 1'b1, t, $urandom_range(0, 1023), $urandom);
            end
        end
        repeat (20) @(negedge clk);
        check("wb_queue_drained", 64'(exp_wb.size()), 64'd0);
        check("req_queue_drained", 64'(exp_req.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RISC-V integer pipeline.
- Consumes the EX-stage result bundle and issues load/store requests to the data memory over a valid/ready request channel with a response channel.
- Aligns and extends load data, then registers the result into the WB stage register.
- Drives the MEM and WB forwarding sources and the data-miss stall back to decode/execute.

Parameters:
- XLEN, 32, datapath width (32 only).
- ADDR_W, 32, data-memory byte-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX slot holds a real instruction (0 = bubble)
- ex_wb_addr  in  5  destination register
- ex_rf_wen  in  1  register write enable
- ex_mem_val  in  1  instruction accesses memory
- ex_mem_fcn  in  1  0 = load (M_XRD), 1 = store (M_XWR)
- ex_mem_typ  in  3  access type: 1 = B, 2 = H, 3 = W, 5 = BU, 6 = HU
- ex_alu_out  in  XLEN  ALU result / effective address
- ex_rs2_data  in  XLEN  store data
- mem_stall  out  1  data-miss stall to upstream stages (cmiss_stall)
- ms_wb_addr  out  5  MEM forwarding destination
- ms_rf_wen  out  1  MEM forwarding write enable
- ms_wb_data  out  XLEN  MEM forwarding data (mem_wb_data)
- wb_wb_addr  out  5  WB register destination
- wb_rf_wen  out  1  WB register write enable
- wb_wb_data  out  XLEN  WB register data
- dmem_req_valid  out  1  request valid
- dmem_req_ready  in  1  request accepted
- dmem_req_addr  out  ADDR_W  word-aligned address
- dmem_req_fcn  out  1  0 = read, 1 = write
- dmem_req_wdata  out  XLEN  lane-replicated store data
- dmem_req_wmask  out  XLEN/8  byte strobes
- dmem_resp_valid  in  1  response valid (read data or store ack)
- dmem_resp_data  in  XLEN  read word

Behaviour:
- **Reset.** All outputs and the internal MS and WB registers reset to 0; FSM resets to IDLE. Reset is legal mid-transaction: the outstanding request is abandoned.
- **MS register.** Captures ex_* at posedge when mem_stall = 0; holds while mem_stall = 1. A captured bubble has ex_valid = 0, which forces rf_wen and mem_val to 0.
- **mem_op** = ms.valid && ms.mem_val.
- **FSM states:** IDLE, REQ, WAIT.
  - IDLE: when mem_op, assert dmem_req_valid. If ready, go to WAIT; else go to REQ.
  - REQ: hold dmem_req_valid and all request fields stable until ready, then go to WAIT.
  - WAIT: on dmem_resp_valid, go to IDLE.
  - Only one outstanding request.
  - A response arriving in IDLE or REQ is ignored (covers stale responses after reset).
- **mem_stall** (combinational) = mem_op && !(state == WAIT && dmem_resp_valid). Minimum load/store latency, with ready and response both immediate, is one stall cycle.
- **Request fields.**
  - addr = {alu_out[ADDR_W-1:2], 2'b00}.
  - Store data: B replicates byte 4×; H replicates half 2×.
  - wmask: B = 1 << addr[1:0]; H = 0011 << addr[1]*2; W = 1111.
  - Loads drive wmask = 0.
- **Load alignment.** Shift resp_data right by addr[1:0]*8, then extend:
  - B/H sign-extend.
  - BU/HU zero-extend.
  - W passes through.
- **ms_wb_data.** Aligned load data when mem_op is a load and completing this cycle; otherwise ms.alu_out. While a load is stalled, ms_rf_wen is still driven but ms_wb_data is invalid. Upstream must treat a mem_stall load as not forwardable.
- **WB register.** Each posedge:
  - If mem_stall, capture a bubble (rf_wen = 0, wb_addr = 0).
  - Otherwise capture ms_wb_addr, ms_rf_wen && ms.valid, and ms_wb_data.
- **Simultaneous events.**
  - Response and a new EX instruction in the same cycle: the new instruction enters MS at that edge; its request can issue the following cycle.
  - Back-to-back memory ops each incur their own handshake.
- Non-memory instructions pass through MS→WB in 1 cycle with no stall.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- **Defined:**
  - An H/HU access with addr[0] = 1, or a W access with addr[1:0] ≠ 0, issues no request and raises no stall.
  - Output ms_misalign (1 bit) pulses high for the cycle the op sits in MS.
  - Output ms_badaddr (ADDR_W) carries alu_out during that pulse.
  - The op's rf_wen is suppressed into WB.
- **Undefined:**
  - Ports ms_misalign and ms_badaddr are absent.
  - Low address bits are truncated to the access size: H clears addr[0]; W clears addr[1:0].
  - The access proceeds normally.

Test Plan:
1. **ALU passthrough.** ADD result 0x0000_1234, wb_addr 5, rf_wen 1 → ms_wb_data = 0x1234 next cycle; wb_wb_data = 0x1234 one cycle later; mem_stall never asserted.
2. **LB sign-extend.** LB at 0x103, ready = 1, response 0x80AA_BBCC one cycle after request → one stall cycle, then wb_wb_data = 0xFFFF_FF80. Same access as LBU → 0x0000_0080.
3. **SH lane placement.** SH at 0x202, rs2 = 0x1234_ABCD → addr 0x200, wdata 0xABCD_ABCD, wmask 1100, fcn 1. Stall is held until the ack; wb_rf_wen = 0.
4. **Request backpressure.** Ready held low 3 cycles for LW at 0x40 → req_valid and address stable for all 4 cycles; mem_stall high until response; WB receives bubbles meanwhile.
5. **Reset mid-operation.** Assert rst_n low while in WAIT, then deliver a late resp_valid after reset → FSM stays IDLE, all outputs 0, response ignored.
6. **Misaligned access.** With MEM_MISALIGN_TRAP_EN, LW at 0x42 → no request, ms_misalign = 1, ms_badaddr = 0x42, wb_rf_wen = 0. Without it → request at 0x40 and normal completion.
